// File: rtl/debug_slave_pkg.sv
// Shared constants for the debug slave system-clock command queue.
package debug_slave_pkg;

  // JTAG instruction codes
  localparam int unsigned IR_OCIMEM    = 0;
  localparam int unsigned IR_TRACEMEM  = 1;
  localparam int unsigned IR_BREAK     = 2;
  localparam int unsigned IR_TRACECTRL = 3;

  // Position of the "action" flag in the scan register
  localparam int unsigned DEFAULT_ACT_BIT = 37;

  // Width of the optional per-entry cycle timestamp
  localparam int unsigned TS_WIDTH = 16;

endpackage

// File: rtl/debug_slave_sysclk_cmdq_if.sv
// JTAG-side inputs and CPU-side command handshake of the debug slave command queue.
// cmd_ts exists only when DBG_CMDQ_TIMESTAMP_EN is defined.
interface debug_slave_sysclk_cmdq_if #(
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned SR_WIDTH = 38,
  parameter int unsigned DEPTH    = 4
);
  localparam int unsigned ACT_W = 1 << IR_WIDTH;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [IR_WIDTH-1:0] ir_in;
  logic [SR_WIDTH-1:0] sr;
  logic                vs_udr;
  logic                vs_uir;
  logic                cmd_ready;
  logic                overflow_clr;
  logic                cmd_valid;
  logic [SR_WIDTH-1:0] jdo;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [ACT_W-1:0]    take_action;
  logic [ACT_W-1:0]    take_no_action;
  logic                ir_update;
  logic                overflow;
  logic [LVL_W-1:0]    level;
`ifdef DBG_CMDQ_TIMESTAMP_EN
  logic [15:0]         cmd_ts;
`endif

  modport slave (
    input  ir_in, sr, vs_udr, vs_uir, cmd_ready, overflow_clr,
    output cmd_valid, jdo, cmd_ir, take_action, take_no_action, ir_update, overflow, level
`ifdef DBG_CMDQ_TIMESTAMP_EN
    , output cmd_ts
`endif
  );

  modport master (
    output ir_in, sr, vs_udr, vs_uir, cmd_ready, overflow_clr,
    input  cmd_valid, jdo, cmd_ir, take_action, take_no_action, ir_update, overflow, level
`ifdef DBG_CMDQ_TIMESTAMP_EN
    , input cmd_ts
`endif
  );

endinterface

// File: rtl/debug_sync_edge.sv
// Multi-flop synchroniser followed by a registered rising-edge pulse.
// A strobe that is already high when reset releases is ignored until it has been seen low.
module debug_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_strobe,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  logic                   r_armed;
  logic                   r_pulse;
  logic                   w_sync;
  logic                   w_fill_done;

  assign w_sync      = r_sync[SYNC_STAGES-1];
  // r_fill marks when the synchroniser output reflects the real input after reset
  assign w_fill_done = r_fill[SYNC_STAGES-1];
  assign o_pulse     = r_pulse;

  // Synchronise, arm on first observed low level, register the rising-edge pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_strobe};
      r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev  <= w_sync;
      r_armed <= r_armed | (w_fill_done & ~w_sync);
      r_pulse <= r_armed & w_sync & ~r_prev;
    end
  end

endmodule

// File: rtl/debug_slave_sysclk_cmdq.sv
// System-clock side of the debug slave: synchronises update-DR/IR strobes, queues
// {ir_in, sr} commands and decodes pops into one-hot action pulses.
// Optional per-entry timestamp: define DBG_CMDQ_TIMESTAMP_EN.
module debug_slave_sysclk_cmdq
  import debug_slave_pkg::*;
#(
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned SR_WIDTH    = 38,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACT_BIT     = DEFAULT_ACT_BIT
) (
  input logic                      clk,
  input logic                      reset_n,
  debug_slave_sysclk_cmdq_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ACT_W = 1 << IR_WIDTH;

  logic [SR_WIDTH-1:0] r_mem_sr [DEPTH];
  logic [IR_WIDTH-1:0] r_mem_ir [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_overflow;
  logic [ACT_W-1:0]    r_take_act;
  logic [ACT_W-1:0]    r_take_no;

  logic                w_push;
  logic                w_uir_pulse;
  logic                w_valid;
  logic                w_full;
  logic                w_pop;
  logic                w_push_ok;
  logic                w_ovf_set;
  logic [SR_WIDTH-1:0] w_head_sr;
  logic [IR_WIDTH-1:0] w_head_ir;
  logic [ACT_W-1:0]    w_onehot;

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .i_strobe (bus.vs_udr),
    .o_pulse  (w_push)
  );

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .i_strobe (bus.vs_uir),
    .o_pulse  (w_uir_pulse)
  );

  assign w_valid   = (r_level != '0);
  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_pop     = w_valid & bus.cmd_ready;
  // A full queue still accepts a push when the head leaves in the same cycle
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;
  // Gate with valid so unwritten storage never reaches the outputs
  assign w_head_sr = w_valid ? r_mem_sr[r_rptr] : '0;
  assign w_head_ir = w_valid ? r_mem_ir[r_rptr] : '0;
  assign w_onehot  = ACT_W'(1) << w_head_ir;

  // Command storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_sr[r_wptr] <= bus.sr;
      r_mem_ir[r_wptr] <= bus.ir_in;
    end
  end

  // Queue pointers, occupancy, sticky overflow and registered action decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_take_act <= '0;
      r_take_no  <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_level    <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop);
      r_overflow <= w_ovf_set | (r_overflow & ~bus.overflow_clr);
      r_take_act <= (w_pop &  w_head_sr[ACT_BIT]) ? w_onehot : '0;
      r_take_no  <= (w_pop & ~w_head_sr[ACT_BIT]) ? w_onehot : '0;
    end
  end

`ifdef DBG_CMDQ_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;
  logic [TS_WIDTH-1:0] r_mem_ts [DEPTH];

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ts <= '0;
    else          r_ts <= r_ts + 1'b1;
  end

  // Timestamp captured alongside each accepted command
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem_ts[r_wptr] <= r_ts;
  end

  assign bus.cmd_ts = w_valid ? r_mem_ts[r_rptr] : '0;
`endif

  assign bus.cmd_valid      = w_valid;
  assign bus.jdo            = w_head_sr;
  assign bus.cmd_ir         = w_head_ir;
  assign bus.take_action    = r_take_act;
  assign bus.take_no_action = r_take_no;
  assign bus.ir_update      = w_uir_pulse;
  assign bus.overflow       = r_overflow;
  assign bus.level          = r_level;

endmodule

// File: tb/tb_debug_slave_sysclk_cmdq.sv
// Directed bench for debug_slave_sysclk_cmdq with default parameters.
module tb_debug_slave_sysclk_cmdq;
  import debug_slave_pkg::*;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  debug_slave_sysclk_cmdq_if bus ();

  debug_slave_sysclk_cmdq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ir;
    logic        act;
    logic [31:0] lo;
    logic [3:0]  exp_act;
    logic [3:0]  exp_no;
  } vec_t;

  vec_t vecs [5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  function automatic logic [37:0] mk_sr(input logic act, input logic [31:0] lo);
    mk_sr = '0;
    mk_sr[37] = act;
    mk_sr[31:0] = lo;
  endfunction

  // Raise vs_udr; returns in the cycle the synchronised push pulse is high
  task automatic udr_rise(input logic [1:0] ir, input logic [37:0] s);
    bus.ir_in  = ir;
    bus.sr     = s;
    bus.vs_udr = 1'b1;
    repeat (3) tick();
  endtask

  task automatic udr_fall;
    tick();
    bus.vs_udr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic push(input logic [1:0] ir, input logic [37:0] s);
    udr_rise(ir, s);
    udr_fall();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.cmd_valid && n < 20) begin
      tick();
      n++;
    end
    check(name, 64'(bus.cmd_valid), 64'd1);
  endtask

  // Pop the head, expecting its low byte
  task automatic pop_expect(input string name, input logic [7:0] lo);
    check(name, 64'(bus.jdo[7:0]), 64'(lo));
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{ir: 2'd0, act: 1'b0, lo: 32'h0000_1111, exp_act: 4'b0000, exp_no: 4'b0001};
    vecs[1] = '{ir: 2'd1, act: 1'b1, lo: 32'h0000_2222, exp_act: 4'b0010, exp_no: 4'b0000};
    vecs[2] = '{ir: 2'd3, act: 1'b0, lo: 32'h0000_3333, exp_act: 4'b0000, exp_no: 4'b1000};
    vecs[3] = '{ir: 2'd2, act: 1'b0, lo: 32'h0000_4444, exp_act: 4'b0000, exp_no: 4'b0100};
    vecs[4] = '{ir: 2'd3, act: 1'b1, lo: 32'h0000_5555, exp_act: 4'b1000, exp_no: 4'b0000};

    reset_n          = 1'b0;
    bus.ir_in        = '0;
    bus.sr           = '0;
    bus.vs_udr       = 1'b0;
    bus.vs_uir       = 1'b0;
    bus.cmd_ready    = 1'b0;
    bus.overflow_clr = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_valid", 64'(bus.cmd_valid), 64'd0);
    check("rst_level", 64'(bus.level), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_jdo", 64'(bus.jdo), 64'd0);
    check("rst_actions", 64'({bus.take_action, bus.take_no_action, bus.ir_update}), 64'd0);
    reset_n = 1'b1;
    repeat (5) tick();

    // Single command with consumer ready: latency and action pulse
    bus.cmd_ready = 1'b1;
    udr_rise(2'(IR_BREAK), mk_sr(1'b1, 32'hDEAD_BEEF));
    check("lat_not_yet", 64'(bus.cmd_valid), 64'd0);
    tick();
    check("lat_valid", 64'(bus.cmd_valid), 64'd1);
    check("lat_jdo", 64'(bus.jdo[31:0]), 64'hDEAD_BEEF);
    check("lat_ir", 64'(bus.cmd_ir), 64'd2);
    tick();
    check("single_act", 64'(bus.take_action), 64'b0100);
    check("single_no", 64'(bus.take_no_action), 64'd0);
    check("single_level", 64'(bus.level), 64'd0);
    tick();
    check("single_act_end", 64'(bus.take_action), 64'd0);
    bus.vs_udr    = 1'b0;
    bus.cmd_ready = 1'b0;
    repeat (3) tick();

    // Decode table
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].ir, mk_sr(vecs[i].act, vecs[i].lo));
      wait_valid($sformatf("vec%0d_valid", i));
      check($sformatf("vec%0d_jdo", i), 64'(bus.jdo[31:0]), 64'(vecs[i].lo));
      check($sformatf("vec%0d_ir", i), 64'(bus.cmd_ir), 64'(vecs[i].ir));
      bus.cmd_ready = 1'b1;
      tick();
      bus.cmd_ready = 1'b0;
      check($sformatf("vec%0d_act", i), 64'(bus.take_action), 64'(vecs[i].exp_act));
      check($sformatf("vec%0d_no", i), 64'(bus.take_no_action), 64'(vecs[i].exp_no));
      tick();
      check($sformatf("vec%0d_clear", i),
            64'({bus.take_action, bus.take_no_action}), 64'd0);
    end

    // Backpressure and overflow
    for (int i = 1; i <= 5; i++) push(2'd1, mk_sr(1'b0, 32'(i)));
    check("ovf_level", 64'(bus.level), 64'd4);
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovf_drain%0d", i), 8'(i));
    check("ovf_empty", 64'(bus.cmd_valid), 64'd0);
    check("ovf_sticky", 64'(bus.overflow), 64'd1);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    check("ovf_clr", 64'(bus.overflow), 64'd0);

    // Full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) push(2'd0, mk_sr(1'b0, 32'h10 + 32'(i)));
    check("full_level", 64'(bus.level), 64'd4);
    udr_rise(2'd0, mk_sr(1'b0, 32'h14));
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    check("pp_level", 64'(bus.level), 64'd4);
    check("pp_overflow", 64'(bus.overflow), 64'd0);
    bus.vs_udr = 1'b0;
    repeat (3) tick();
    for (int i = 1; i <= 4; i++) pop_expect($sformatf("pp_drain%0d", i), 8'h10 + 8'(i));
    check("pp_level_end", 64'(bus.level), 64'd0);

    // IR strobe leaves queue untouched
    push(2'd1, mk_sr(1'b1, 32'hA1));
    push(2'd1, mk_sr(1'b1, 32'hA2));
    begin
      int c = 0;
      bus.vs_uir = 1'b1;
      for (int k = 0; k < 10; k++) begin
        if (k == 4) bus.vs_uir = 1'b0;
        tick();
        c += int'(bus.ir_update);
      end
      check("uir_pulses", 64'(c), 64'd1);
    end
    check("uir_level", 64'(bus.level), 64'd2);
    check("uir_jdo", 64'(bus.jdo[7:0]), 64'hA1);

    // Reset mid-stream, strobe held across release
    push(2'd1, mk_sr(1'b1, 32'hA3));
    check("mid_level", 64'(bus.level), 64'd3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.cmd_valid), 64'd0);
    check("mid_rst_level", 64'(bus.level), 64'd0);
    bus.vs_udr    = 1'b1;
    bus.cmd_ready = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    begin
      int bad = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (bus.cmd_valid || bus.level != '0 || bus.take_action != '0 ||
            bus.take_no_action != '0) bad++;
      end
      check("mid_no_push", 64'(bad), 64'd0);
    end
    bus.vs_udr    = 1'b0;
    bus.cmd_ready = 1'b0;
    repeat (3) tick();
    push(2'd3, mk_sr(1'b1, 32'hC0DE));
    check("post_level", 64'(bus.level), 64'd1);
    check("post_jdo", 64'(bus.jdo[31:0]), 64'hC0DE);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    check("post_act", 64'(bus.take_action), 64'b1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
